// File: rtl/tmds_rx_word_align_if.sv
// Chunk-in / character-out bus of one TMDS receive channel's word aligner.
// din_vld qualifies din with no backpressure; dout_vld is a one-cycle strobe that qualifies dout and is_token.
interface tmds_rx_word_align_if;
  logic [4:0] din;
  logic       din_vld;
  logic       force_resync;
  logic [9:0] dout;
  logic       dout_vld;
  logic       is_token;
  logic       aligned;
  logic [3:0] offset;
  logic [1:0] state;

  modport master (
    output din, din_vld, force_resync,
    input  dout, dout_vld, is_token, aligned, offset, state
  );

  modport slave (
    input  din, din_vld, force_resync,
    output dout, dout_vld, is_token, aligned, offset, state
  );
endinterface

// File: rtl/tmds_rx_word_align.sv
// Assembles 5-bit deserializer chunks into 10-bit TMDS characters and hunts for the
// bit offset at which control tokens appear, holding lock until tokens stop arriving.
module tmds_rx_word_align #(
  parameter int TOKEN_COUNT  = 32,
  parameter int SEARCH_WORDS = 2048,
  parameter int LOSS_WORDS   = 16384
) (
  input logic pclkx2,
  input logic rstin,
  tmds_rx_word_align_if.slave bus
);
  localparam int TOK_W  = (TOKEN_COUNT  > 1) ? $clog2(TOKEN_COUNT)  : 1;
  localparam int SRCH_W = (SEARCH_WORDS > 1) ? $clog2(SEARCH_WORDS) : 1;
  localparam int LOSS_W = (LOSS_WORDS   > 1) ? $clog2(LOSS_WORDS)   : 1;
  localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(TOKEN_COUNT - 1);
  localparam logic [SRCH_W-1:0] SRCH_LAST = SRCH_W'(SEARCH_WORDS - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WORDS - 1);

  typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [3:0]        offset, offset_nxt;
  logic [SRCH_W-1:0] srch_cnt, srch_cnt_nxt;
  logic [TOK_W-1:0]  tok_cnt, tok_cnt_nxt;
  logic [LOSS_W-1:0] loss_cnt, loss_cnt_nxt;
  logic              aligned, aligned_nxt;

  logic [19:0] hist;
  logic        phase;
  logic [9:0]  dout;
  logic        dout_vld;
  logic        is_token;

  logic [19:0] new_hist;
  logic [9:0]  w;
  logic        w_tok;
  logic        word_evt;
  logic        srch_wrap;

  function automatic logic [3:0] offset_inc(input logic [3:0] o);
    return (o == 4'd9) ? 4'd0 : o + 4'd1;
  endfunction

  // Candidate word is taken from the post-shift history so the completing chunk is included.
  always_comb begin
    new_hist  = {bus.din, hist[19:5]};
    w         = 10'(new_hist >> offset);
    w_tok     = (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
    word_evt  = bus.din_vld && phase;
    srch_wrap = (srch_cnt == SRCH_LAST);
  end

  always_comb begin
    state_nxt    = state;
    offset_nxt   = offset;
    srch_cnt_nxt = srch_cnt;
    tok_cnt_nxt  = tok_cnt;
    loss_cnt_nxt = loss_cnt;
    aligned_nxt  = aligned;
    if (bus.force_resync) begin
      state_nxt    = SEARCH;
      offset_nxt   = 4'd0;
      srch_cnt_nxt = '0;
      tok_cnt_nxt  = '0;
      loss_cnt_nxt = '0;
      aligned_nxt  = 1'b0;
    end else if (word_evt) begin
      unique case (state)
        SEARCH: begin
          if (w_tok) begin
            tok_cnt_nxt = TOK_W'(1);
            state_nxt   = CHECK;
          end else begin
            srch_cnt_nxt = srch_wrap ? '0 : srch_cnt + 1'b1;
            if (srch_wrap) offset_nxt = offset_inc(offset);
          end
        end
        CHECK: begin
          if (w_tok) begin
            if (tok_cnt == TOK_LAST) begin
              tok_cnt_nxt  = '0;
              loss_cnt_nxt = '0;
              aligned_nxt  = 1'b1;
              state_nxt    = LOCKED;
            end else begin
              tok_cnt_nxt = tok_cnt + 1'b1;
            end
          end else begin
            // The aborting word still counts toward the search dwell, so false tokens cannot pin the offset.
            tok_cnt_nxt  = '0;
            state_nxt    = SEARCH;
            srch_cnt_nxt = srch_wrap ? '0 : srch_cnt + 1'b1;
            if (srch_wrap) offset_nxt = offset_inc(offset);
          end
        end
        LOCKED: begin
          if (w_tok) begin
            loss_cnt_nxt = '0;
          end else if (loss_cnt == LOSS_LAST) begin
            state_nxt    = SEARCH;
            aligned_nxt  = 1'b0;
            offset_nxt   = offset_inc(offset);
            srch_cnt_nxt = '0;
          end else begin
            loss_cnt_nxt = loss_cnt + 1'b1;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge pclkx2 or posedge rstin) begin
    if (rstin) begin
      state    <= SEARCH;
      offset   <= 4'd0;
      srch_cnt <= '0;
      tok_cnt  <= '0;
      loss_cnt <= '0;
      aligned  <= 1'b0;
    end else begin
      state    <= state_nxt;
      offset   <= offset_nxt;
      srch_cnt <= srch_cnt_nxt;
      tok_cnt  <= tok_cnt_nxt;
      loss_cnt <= loss_cnt_nxt;
      aligned  <= aligned_nxt;
    end
  end

  always_ff @(posedge pclkx2 or posedge rstin) begin
    if (rstin) begin
      hist     <= 20'd0;
      phase    <= 1'b0;
      dout     <= 10'd0;
      dout_vld <= 1'b0;
      is_token <= 1'b0;
    end else begin
      if (bus.din_vld) begin
        hist  <= new_hist;
        phase <= ~phase;
      end
      dout_vld <= word_evt;
      if (word_evt) begin
        dout     <= w;
        is_token <= w_tok;
      end
    end
  end

  assign bus.dout     = dout;
  assign bus.dout_vld = dout_vld;
  assign bus.is_token = is_token;
  assign bus.aligned  = aligned;
  assign bus.offset   = offset;
  assign bus.state    = state;
endmodule

// File: tb/tb_tmds_rx_word_align.sv
// Randomized bench for tmds_rx_word_align: a serial-bit-stream reference model predicts
// every character, strobe, offset and lock flag, with scenario checkpoints on top.
module tb_tmds_rx_word_align;
  localparam int TOKEN_COUNT  = 32;
  localparam int SEARCH_WORDS = 16;
  localparam int LOSS_WORDS   = 64;
  localparam int M_SEARCH = 0, M_CHECK = 1, M_LOCKED = 2;

  logic pclkx2 = 1'b0;
  logic rstin  = 1'b1;

  tmds_rx_word_align_if bus();

  tmds_rx_word_align #(
    .TOKEN_COUNT (TOKEN_COUNT),
    .SEARCH_WORDS(SEARCH_WORDS),
    .LOSS_WORDS  (LOSS_WORDS)
  ) dut (
    .pclkx2(pclkx2),
    .rstin (rstin),
    .bus   (bus)
  );

  // clock / reset
  always #5 pclkx2 = ~pclkx2;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  bit         stream[$];
  bit         tx_q[$];
  logic [9:0] exp_q[$];
  int         m_chunks, m_mode, m_off, m_srch, m_tok, m_loss;
  bit         m_aligned, exp_vld;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_tok(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  // reference model: the serial bit stream since reset, bit 0 first
  task automatic model_resync();
    m_mode = M_SEARCH; m_off = 0; m_srch = 0; m_tok = 0; m_loss = 0; m_aligned = 0;
  endtask

  task automatic model_clear();
    stream.delete(); exp_q.delete(); tx_q.delete();
    m_chunks = 0; exp_vld = 0;
    model_resync();
  endtask

  function automatic logic [9:0] model_word();
    logic [9:0] w;
    int base = stream.size() - 20 + m_off;
    for (int j = 0; j < 10; j++) w[j] = (base + j < 0) ? 1'b0 : stream[base + j];
    return w;
  endfunction

  task automatic model_search_miss();
    m_srch++;
    if (m_srch == SEARCH_WORDS) begin
      m_srch = 0;
      m_off  = (m_off + 1) % 10;
    end
  endtask

  task automatic model_fsm(input logic [9:0] w);
    bit t = is_tok(w);
    if (m_mode == M_SEARCH) begin
      if (t) begin m_tok = 1; m_mode = M_CHECK; end
      else model_search_miss();
    end else if (m_mode == M_CHECK) begin
      if (t) begin
        m_tok++;
        if (m_tok == TOKEN_COUNT) begin m_mode = M_LOCKED; m_aligned = 1; m_loss = 0; end
      end else begin
        m_tok = 0; m_mode = M_SEARCH;
        model_search_miss();
      end
    end else begin
      if (t) m_loss = 0;
      else begin
        m_loss++;
        if (m_loss == LOSS_WORDS) begin
          m_mode = M_SEARCH; m_aligned = 0; m_srch = 0; m_loss = 0;
          m_off = (m_off + 1) % 10;
        end
      end
    end
  endtask

  task automatic model_step(input logic [4:0] c, input logic vld, input logic frc);
    logic [9:0] w;
    exp_vld = 0;
    if (vld) begin
      for (int j = 0; j < 5; j++) stream.push_back(c[j]);
      m_chunks++;
      if (m_chunks % 2 == 0) begin
        w = model_word();
        exp_vld = 1;
        exp_q.push_back(w);
        if (!frc) model_fsm(w);
      end
    end
    if (frc) model_resync();
  endtask

  // scoreboard
  task automatic compare_outputs();
    logic [9:0] ew;
    check("dout_vld", bus.dout_vld, exp_vld);
    if (exp_vld && exp_q.size() > 0) begin
      ew = exp_q.pop_front();
      check("dout", bus.dout, ew);
      check("is_token", bus.is_token, is_tok(ew));
    end
    check("aligned", bus.aligned, m_aligned);
    check("offset", bus.offset, m_off);
  endtask

  // drivers
  task automatic cycle(input logic [4:0] c, input logic vld, input logic frc);
    @(negedge pclkx2);
    bus.din = c; bus.din_vld = vld; bus.force_resync = frc;
    @(posedge pclkx2);
    #1;
    model_step(c, vld, frc);
    compare_outputs();
    bus.force_resync = 1'b0;
  endtask

  task automatic flush_tx();
    logic [4:0] c;
    while (tx_q.size() >= 5) begin
      for (int j = 0; j < 5; j++) c[j] = tx_q.pop_front();
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 5)) cycle(5'($urandom), 1'b0, 1'b0);
      cycle(c, 1'b1, 1'b0);
    end
  endtask

  task automatic push_word(input logic [9:0] w, input int n);
    repeat (n) begin
      for (int j = 0; j < 10; j++) tx_q.push_back(w[j]);
      flush_tx();
    end
  endtask

  task automatic push_data(input int n);
    logic [9:0] w;
    repeat (n) begin
      do w = 10'($urandom_range(0, 1023)); while (is_tok(w));
      push_word(w, 1);
    end
  endtask

  task automatic push_rand_bits(input int n);
    repeat (n) tx_q.push_back(1'($urandom));
  endtask

  task automatic async_reset_check(input string tag);
    @(negedge pclkx2);
    bus.din_vld = 1'b0;
    #2 rstin = 1'b1;
    #1;
    check({tag, "_dout"}, bus.dout, 10'd0);
    check({tag, "_dout_vld"}, bus.dout_vld, 1'b0);
    check({tag, "_is_token"}, bus.is_token, 1'b0);
    check({tag, "_aligned"}, bus.aligned, 1'b0);
    check({tag, "_offset"}, bus.offset, 4'd0);
    model_clear();
    repeat (2) @(posedge pclkx2);
    @(negedge pclkx2);
    rstin = 1'b0;
  endtask

  initial begin
    bus.din = 5'd0; bus.din_vld = 1'b0; bus.force_resync = 1'b0;
    model_clear();
    repeat (3) @(posedge pclkx2);
    #1;
    check("rst_dout", bus.dout, 10'd0);
    check("rst_dout_vld", bus.dout_vld, 1'b0);
    check("rst_is_token", bus.is_token, 1'b0);
    check("rst_aligned", bus.aligned, 1'b0);
    check("rst_offset", bus.offset, 4'd0);
    @(negedge pclkx2);
    rstin = 1'b0;

    // token stream shifted by 3 bits: offset walks up to 3 and locks
    push_rand_bits(3);
    push_word(10'h354, 100);
    check("t1_aligned", bus.aligned, 1'b1);
    check("t1_offset", bus.offset, 4'd3);

    // already aligned at offset 0
    async_reset_check("t2_rst");
    push_word(10'h0AB, 40);
    check("t2_aligned", bus.aligned, 1'b1);
    check("t2_offset", bus.offset, 4'd0);

    // one data word inside a token run aborts the check
    async_reset_check("t3_rst");
    push_word(10'h154, 5);
    push_word(10'h1F0, 1);
    push_word(10'h154, 31);
    check("t3_early", bus.aligned, 1'b0);
    push_word(10'h154, 9);
    check("t3_locked", bus.aligned, 1'b1);

    // loss of lock: a token just before the limit keeps lock, a full run drops it
    push_data(62);
    push_word(10'h2AB, 1);
    check("t4_hold", bus.aligned, 1'b1);
    push_data(70);
    check("t4_lost", bus.aligned, 1'b0);
    check("t4_offset", bus.offset, 4'd1);

    // force_resync while locked at offset 7, then relock
    async_reset_check("t5_rst");
    push_rand_bits(7);
    push_word(10'h2AB, 180);
    check("t5_aligned", bus.aligned, 1'b1);
    check("t5_offset", bus.offset, 4'd7);
    cycle(5'($urandom), 1'b0, 1'b1);
    check("t5_rs_aligned", bus.aligned, 1'b0);
    check("t5_rs_offset", bus.offset, 4'd0);
    check("t5_rs_state", bus.state, 2'd0);
    push_word(10'h2AB, 180);
    check("t5_relock", bus.aligned, 1'b1);
    check("t5_reoffset", bus.offset, 4'd7);

    // asynchronous reset while locked
    async_reset_check("t6_rst");
    push_data(10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
